// File: rtl/rcw_pkg.sv
// Shared types and defaults for the read-conditional-write sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rcw_pkg;

    localparam int          RCW_DEPTH_DEFAULT     = 4;
    localparam logic [31:0] RCW_PARK_ADDR_DEFAULT = 32'h7;

    // One queued command: target word address plus operation select.
    typedef struct packed {
        logic [31:0] addr;
        logic        inc;   // 1: mem[addr]++, 0: mem[addr] = mem[addr+4]
    } rcw_cmd_t;

endpackage

// File: rtl/rcw_cmd_fifo.sv
// Command queue: DEPTH-entry circular buffer of rcw_cmd_t with extra-bit full/empty.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: full blocks pushes (no bypass); pop on empty is ignored.
module rcw_cmd_fifo
    import rcw_pkg::*;
#(
    parameter int DEPTH = RCW_DEPTH_DEFAULT
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     push_vld,
    input  rcw_cmd_t push_dat,
    output logic     full,
    input  logic     pop,
    output rcw_cmd_t head_dat,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    rcw_cmd_t    store_q [DEPTH];
    rcw_cmd_t    store_d [DEPTH];
    logic        do_push;
    logic        do_pop;

    // Pointers share an index when the queue is empty or full; the extra MSB tells them apart.
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push  = push_vld && !full;
    assign do_pop   = pop && !empty;
    assign head_dat = store_q[rd_ptr_q[AW-1:0]];

    // Next pointer values and storage write; push and pop may happen together.
    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
        store_d  = store_q;
        if (do_push) begin
            store_d[wr_ptr_q[AW-1:0]] = push_dat;
        end
    end

    // Pointer registers; reset empties the queue.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage holds data only, so it needs no reset.
    always_ff @(posedge clk) begin
        store_q <= store_d;
    end

endmodule

// File: rtl/read_cond_write_sequencer.sv
// Queues commands and issues each once to a downstream read-modify-write stage, returning the pre-update word.
// Latency: accept N, issue N+1, rsp_valid N+2; one command per cycle sustained while rsp_ready=1.
// Backpressure: cmd_ready drops when the queue is full; a held response stalls issue. Option: RCW_SEQ_STATS_EN.
module read_cond_write_sequencer
    import rcw_pkg::*;
#(
    parameter int          DEPTH     = RCW_DEPTH_DEFAULT,
    parameter logic [31:0] PARK_ADDR = RCW_PARK_ADDR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_addr,
    input  logic        cmd_inc,
    output logic        mem_enable,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [31:0] rsp_addr
`ifdef RCW_SEQ_STATS_EN
    ,
    output logic [15:0] stat_issued,
    output logic [15:0] stat_stall
`endif
);

    rcw_cmd_t    push_dat;
    rcw_cmd_t    head_dat;
    logic        fifo_full;
    logic        fifo_empty;
    logic        issue;
    logic        live_q, live_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic [31:0] rsp_addr_q, rsp_addr_d;

    assign push_dat  = '{addr: cmd_addr, inc: cmd_inc};
    assign cmd_ready = live_q && !fifo_full;

    rcw_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_cmd_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_vld (cmd_valid && cmd_ready),
        .push_dat (push_dat),
        .full     (fifo_full),
        .pop      (issue),
        .head_dat (head_dat),
        .empty    (fifo_empty)
    );

    // Issue the head only when the response slot is free or being drained; otherwise park,
    // since the downstream stage writes every cycle and must only touch the park word.
    always_comb begin
        issue      = !fifo_empty && (!rsp_valid_q || rsp_ready);
        mem_addr   = PARK_ADDR;
        mem_enable = 1'b0;
        if (issue) begin
            mem_addr   = head_dat.addr;
            mem_enable = head_dat.inc;
        end
    end

    // Response slot: load the pre-update word on issue, clear on handshake, otherwise hold.
    always_comb begin
        live_d      = 1'b1;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_addr_d  = rsp_addr_q;
        if (issue) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = mem_rdata;
            rsp_addr_d  = head_dat.addr;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // Response and out-of-reset registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            live_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_addr_q  <= '0;
        end else begin
            live_q      <= live_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_addr_q  <= rsp_addr_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_addr  = rsp_addr_q;

`ifdef RCW_SEQ_STATS_EN
    logic [15:0] stat_issued_q, stat_issued_d;
    logic [15:0] stat_stall_q, stat_stall_d;

    // Saturating counts of issues and of cycles a response sits unaccepted.
    always_comb begin
        stat_issued_d = stat_issued_q;
        stat_stall_d  = stat_stall_q;
        if (issue && (stat_issued_q != 16'hFFFF)) begin
            stat_issued_d = stat_issued_q + 16'd1;
        end
        if (rsp_valid_q && !rsp_ready && (stat_stall_q != 16'hFFFF)) begin
            stat_stall_d = stat_stall_q + 16'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_issued_q <= '0;
            stat_stall_q  <= '0;
        end else begin
            stat_issued_q <= stat_issued_d;
            stat_stall_q  <= stat_stall_d;
        end
    end

    assign stat_issued = stat_issued_q;
    assign stat_stall  = stat_stall_q;
`endif

endmodule
